vga_sync_controller: RTL
========================

VGA_SYNC_CONTROLLER -- requirements
Module: vga_sync_controller

Interface
REQ-001 The block SHALL have parameter PIX_DIV, default 4, meaning clk cycles per pixel (100 MHz to 25 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable clk cycles that qualifies a button level.
REQ-003 The block SHALL have port clk, input, 1, meaning the system clock; it is the only clock in the block.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port btnC, input, 1, meaning the raw, asynchronous pushbutton.
REQ-006 The block SHALL have port hsync, output, 1, meaning horizontal sync, active-low.
REQ-007 The block SHALL have port vsync, output, 1, meaning vertical sync, active-low.
REQ-008 The block SHALL have port blanking, output, 1, meaning 1 outside the visible 640x480 region; it drives the color generator blanking input.
REQ-009 The block SHALL have port pix_x, output, 10, meaning the current horizontal count.
REQ-010 The block SHALL have port pix_y, output, 10, meaning the current vertical count.
REQ-011 The block SHALL have port pix_tick, output, 1, meaning a 1-clk pulse each pixel period.
REQ-012 The block SHALL have port frame_start, output, 1, meaning a 1-clk pulse when the counters wrap to (0,0).
REQ-013 The block SHALL have port color_step, output, 1, meaning a 1-clk, frame-aligned request to advance the color pattern.

Function
REQ-014 Divider: counts 0..PIX_DIV-1 and wraps; pix_tick SHALL be 1 on exactly the clk cycle where the divider equals PIX_DIV-1.
REQ-015 Horizontal counter: advances only on pix_tick; range 0..799; wraps 799 -> 0.
REQ-016 Vertical counter: advances only on pix_tick with horizontal count 799; range 0..524; wraps 524 -> 0.
REQ-017 pix_x and pix_y SHALL equal the horizontal and vertical counter registers directly, with zero added latency.
REQ-018 hsync SHALL be 0 iff pix_x is in 656..751; otherwise 1.
REQ-019 vsync SHALL be 0 iff pix_y is in 490..491; otherwise 1.
REQ-020 blanking SHALL be 1 iff pix_x >= 640 or pix_y >= 480.
REQ-021 hsync, vsync and blanking SHALL be registered and SHALL change on the same clk edge as the counters they decode; no glitches.
REQ-022 frame_start SHALL be 1 for exactly the single clk cycle after the counters transition (799,524) -> (0,0).
REQ-023 Button path, synchronizer: btnC SHALL pass through a 2-flop synchronizer.
REQ-024 Button path, debouncer: the debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive clks; any bounce SHALL restart the count.
REQ-025 A 0 -> 1 transition of the debounced level SHALL set a pending flag.
REQ-026 Frame-sync state machine: states IDLE, PENDING.
REQ-027 IDLE -> PENDING SHALL occur on a debounced rising edge.
REQ-028 PENDING -> IDLE SHALL occur on frame_start, with color_step = 1 in that same cycle.
REQ-029 Further rising edges while in PENDING SHALL be absorbed, giving at most one color_step per frame.
REQ-030 A rising edge coincident with frame_start while in IDLE SHALL move the machine to PENDING; color_step SHALL issue on the next frame_start.
REQ-031 color_step SHALL never assert while blanking = 0 except at (0,0), and SHALL always coincide with frame_start.
REQ-032 Holding btnC high SHALL produce exactly one color_step; release and a fresh press are required for another.

Reset
REQ-033 While rst = 1, regardless of clk: divider = 0, pix_x = 0, pix_y = 0, hsync = 1, vsync = 1, blanking = 0, pix_tick = 0, frame_start = 0, color_step = 0, synchronizer = 0, debounced level = 0, debounce count = 0, state = IDLE.
REQ-034 Reset asserted mid-frame or mid-debounce SHALL discard all progress, including a pending color_step; after release, the first pix_tick SHALL occur PIX_DIV clks later.

Verification
REQ-035 Scenario: PIX_DIV = 4, release rst -> pix_tick every 4th clk; pix_x reaches 799 and returns to 0 after 3200 clks.
REQ-036 Scenario: run a full line -> hsync low for exactly 96 pixels (384 clks) beginning at pix_x = 656; blanking high from pix_x = 640 through 799.
REQ-037 Scenario: run a full frame -> vsync low on lines 490-491 only; frame_start pulses once, 1,680,000 clks after the first (0,0); blanking high for all of lines 480-524.
REQ-038 Scenario: DEBOUNCE_CYCLES = 4; btnC pulses 1 for 2 clks, 0 for 1 clk, then 1 for 10 clks mid-frame -> exactly one color_step, coincident with the next frame_start; none before it.
REQ-039 Scenario: three clean presses within one frame -> a single color_step at the next frame_start; a press after that frame_start -> a second color_step one frame later.
REQ-040 Scenario: press accepted, then rst pulsed for 3 clks before frame_start -> no color_step; all outputs at their reset values during rst; counters restart at (0,0).

Source files
------------

// File: rtl/vga_sync_controller.sv
// 640x480@60 VGA timing generator with a debounced pushbutton that requests
// one frame-aligned colour-pattern step per press.
`timescale 1ns/1ps
module vga_sync_controller #(
    parameter int PIX_DIV         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC,
    output logic       hsync,
    output logic       vsync,
    output logic       blanking,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       color_step
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd751;
    localparam logic [9:0] H_MAX    = 10'd799;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd491;
    localparam logic [9:0] V_MAX    = 10'd524;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    logic [DIV_W-1:0] div;
    logic [9:0]       hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    logic             h_wrap, v_wrap;

    logic             btn_p0, btn_p1;
    logic             deb;
    logic [DB_W-1:0]  deb_cnt;
    logic             deb_rise;

    state_t           state, state_nxt;

    assign pix_tick = (div == DIV_LAST);
    assign pix_x    = hcnt;
    assign pix_y    = vcnt;
    assign h_wrap   = (hcnt == H_MAX);
    assign v_wrap   = (vcnt == V_MAX);

    always_comb begin
        hcnt_nxt = hcnt;
        vcnt_nxt = vcnt;
        if (pix_tick) begin
            hcnt_nxt = h_wrap ? 10'd0 : hcnt + 10'd1;
            if (h_wrap) begin
                vcnt_nxt = v_wrap ? 10'd0 : vcnt + 10'd1;
            end
        end
    end

    // Sync/blank decode the next counter values so they update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blanking    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= pix_tick ? '0 : div + 1'b1;
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            hsync       <= !((hcnt_nxt >= H_SYNC_S) && (hcnt_nxt <= H_SYNC_E));
            vsync       <= !((vcnt_nxt >= V_SYNC_S) && (vcnt_nxt <= V_SYNC_E));
            blanking    <= (hcnt_nxt >= H_VIS) || (vcnt_nxt >= V_VIS);
            frame_start <= pix_tick && h_wrap && v_wrap;
        end
    end

    // Button: two-flop synchronizer, then a level debouncer that restarts on any bounce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_p0   <= 1'b0;
            btn_p1   <= 1'b0;
            deb      <= 1'b0;
            deb_cnt  <= '0;
            deb_rise <= 1'b0;
        end else begin
            btn_p0   <= btnC;
            btn_p1   <= btn_p0;
            deb_rise <= 1'b0;
            if (btn_p1 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DB_LAST) begin
                deb      <= btn_p1;
                deb_cnt  <= '0;
                deb_rise <= btn_p1;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Presses seen while PENDING are absorbed, giving at most one step per frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (deb_rise) state_nxt = PENDING;
            PENDING: if (frame_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        color_step = (state == PENDING) && frame_start;
    end

endmodule
